// File: rtl/wait_state_memory_if.sv
// Request/response bus between a requester and wait_state_memory.
interface wait_state_memory_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 16
);
  logic                  req;
  logic                  we;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W/8-1:0]   be;
  logic [DATA_W-1:0]     rdata;
  logic                  ack;
  logic                  busy;
  logic                  err;

  modport master (output req, we, addr, wdata, be, input rdata, ack, busy, err);
  modport slave  (input req, we, addr, wdata, be, output rdata, ack, busy, err);
endinterface

// File: rtl/wait_state_memory.sv
// Single-port word memory answering each access after WAIT_CYC wait states.
// Define WAIT_STATE_MEMORY_ADDR_CHECK_EN to flag (and suppress) accesses with addr >= DEPTH.
module wait_state_memory #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned DEPTH    = 1024,
  parameter int unsigned WAIT_CYC = 1
) (
  input  logic                clk,
  input  logic                reset,
  wait_state_memory_if.slave  mem_if
);

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [BE_W-1:0]   be;
  } acc_t;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  acc_t               acc_q, acc_d;
  acc_t               acc_in_c, acc_c;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic               ack_q, ack_d;
  logic               busy_q, busy_d;
  logic               err_q, err_d;
  logic [IDX_W-1:0]   idx_c;
  logic               in_range_c;
  logic               mem_we_c;
  logic [DATA_W-1:0]  mem_q [DEPTH];

  always_comb begin
    acc_in_c.we    = mem_if.we;
    acc_in_c.addr  = mem_if.addr;
    acc_in_c.wdata = mem_if.wdata;
    acc_in_c.be    = mem_if.be;
  end

  // With zero wait states the access completes at the accept edge, so use the live inputs then.
  assign acc_c = (state_q == S_IDLE) ? acc_in_c : acc_q;
  assign idx_c = IDX_W'(acc_c.addr);

`ifdef WAIT_STATE_MEMORY_ADDR_CHECK_EN
  assign in_range_c = ((acc_c.addr >> IDX_W) == '0);
`else
  assign in_range_c = 1'b1;
`endif

  // State register and all output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      rdata_q <= '0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic: accept, count wait states, respond for one cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    case (state_q)
      S_IDLE: begin
        if (mem_if.req) begin
          acc_d = acc_in_c;
          if (WAIT_CYC == 0) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_W'(WAIT_CYC - 1);
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) state_d = S_RESP;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      S_RESP: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output logic: the access is performed on the edge that enters S_RESP.
  always_comb begin
    busy_d   = (state_d != S_IDLE);
    ack_d    = 1'b0;
    err_d    = 1'b0;
    rdata_d  = rdata_q;
    mem_we_c = 1'b0;
    if (state_d == S_RESP) begin
      ack_d = 1'b1;
      err_d = ~in_range_c;
      if (acc_c.we) begin
        mem_we_c = in_range_c & reset;
      end else begin
        rdata_d = in_range_c ? mem_q[idx_c] : '0;
      end
    end
  end

  // Byte-masked memory write; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      for (int i = 0; i < int'(BE_W); i++) begin
        if (acc_c.be[i]) mem_q[idx_c][8*i +: 8] <= acc_c.wdata[8*i +: 8];
      end
    end
  end

  assign mem_if.rdata = rdata_q;
  assign mem_if.ack   = ack_q;
  assign mem_if.busy  = busy_q;
  assign mem_if.err   = err_q;

endmodule

// File: tb/tb_wait_state_memory.sv
// Self-checking bench for wait_state_memory: directed cases plus random accesses against a word-array model.
module tb_wait_state_memory;

  localparam int unsigned DW    = 16;
  localparam int unsigned AW    = 16;
  localparam int unsigned DEPTH = 1024;
  localparam int unsigned W     = 1;
`ifdef WAIT_STATE_MEMORY_ADDR_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic rst_sp_n;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  wait_state_memory_if #(.DATA_W(DW), .ADDR_W(AW)) bus   ();
  wait_state_memory_if #(.DATA_W(DW), .ADDR_W(AW)) bus0  ();
  wait_state_memory_if #(.DATA_W(DW), .ADDR_W(AW)) bus15 ();

  wait_state_memory #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .WAIT_CYC(W))
    u_dut (.clk(clk), .reset(rst_n), .mem_if(bus));
  wait_state_memory #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .WAIT_CYC(0))
    u_w0 (.clk(clk), .reset(rst_sp_n), .mem_if(bus0));
  wait_state_memory #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .WAIT_CYC(15))
    u_w15 (.clk(clk), .reset(rst_sp_n), .mem_if(bus15));

  // Reference: plain word array, expected rdata, and ack timestamps of the throughput instances.
  logic [DW-1:0] model_mem [DEPTH];
  logic [DW-1:0] rd_exp;
  int q0[$];
  int q15[$];

  always @(negedge clk) begin
    if (bus0.ack === 1'b1)  q0.push_back(cyc);
    if (bus15.ack === 1'b1) q15.push_back(cyc);
  end

  function automatic int unsigned idx_of(input logic [AW-1:0] a);
    return int'(a) % DEPTH;
  endfunction

  function automatic bit in_rng(input logic [AW-1:0] a);
    return CHK ? (int'(a) < int'(DEPTH)) : 1'b1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic scramble();
    bus.req   = 1'($urandom);
    bus.we    = 1'($urandom);
    bus.addr  = 16'($urandom);
    bus.wdata = 16'($urandom);
    bus.be    = 2'($urandom);
  endtask

  // One access on the main instance; called just after a falling edge, returns just after one.
  task automatic txn(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [1:0] b);
    int   k;
    logic exp_err;
    bus.req = 1'b1; bus.we = w; bus.addr = a; bus.wdata = d; bus.be = b;
    exp_err = ~in_rng(a);
    if (w) begin
      if (in_rng(a))
        for (int i = 0; i < 2; i++)
          if (b[i]) model_mem[idx_of(a)][8*i +: 8] = d[8*i +: 8];
    end else begin
      rd_exp = in_rng(a) ? model_mem[idx_of(a)] : '0;
    end
    @(posedge clk);
    @(negedge clk);
    chk("busy_after_accept", 32'(bus.busy), 32'd1);
    scramble();
    k = 0;
    while (bus.ack !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
      scramble();
    end
    chk("ack_latency", 32'(k), 32'(W));
    chk("ack_busy", 32'(bus.busy), 32'd1);
    chk("ack_err", 32'(bus.err), 32'(exp_err));
    chk("ack_rdata", 32'(bus.rdata), 32'(rd_exp));
    @(negedge clk);
    chk("ack_one_cycle", 32'(bus.ack), 32'd0);
    chk("busy_released", 32'(bus.busy), 32'd0);
    chk("err_outside_ack", 32'(bus.err), 32'd0);
    chk("rdata_hold", 32'(bus.rdata), 32'(rd_exp));
    bus.req = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; rst_sp_n = 1'b0; rd_exp = '0;
    bus.req = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0; bus.be = '0;
    bus0.req = 1'b1;  bus0.we = 1'b1;  bus0.addr = 16'd9;  bus0.wdata = 16'h0F0F; bus0.be = 2'b11;
    bus15.req = 1'b1; bus15.we = 1'b1; bus15.addr = 16'd9; bus15.wdata = 16'hF0F0; bus15.be = 2'b11;
    repeat (2) @(negedge clk);
    chk("reset_ack", 32'(bus.ack), 32'd0);
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_err", 32'(bus.err), 32'd0);
    chk("reset_rdata", 32'(bus.rdata), 32'd0);
    rst_n = 1'b1; rst_sp_n = 1'b1;

    for (int i = 0; i < 64; i++) txn(1'b1, 16'(i), 16'($urandom), 2'b11);

    // Full write then read back.
    txn(1'b1, 16'd5, 16'hBEEF, 2'b11);
    txn(1'b0, 16'd5, 16'h0000, 2'b00);
    chk("read_beef", 32'(bus.rdata), 32'h0000BEEF);

    // Byte enables, including an all-zero mask.
    txn(1'b1, 16'd7, 16'h1234, 2'b11);
    txn(1'b1, 16'd7, 16'hABCD, 2'b10);
    txn(1'b0, 16'd7, 16'h0000, 2'b01);
    chk("byte_merge", 32'(bus.rdata), 32'h0000AB34);
    txn(1'b1, 16'd7, 16'hFFFF, 2'b00);
    txn(1'b0, 16'd7, 16'h0000, 2'b00);
    chk("be_zero_nochange", 32'(bus.rdata), 32'h0000AB34);

    // Reset one cycle into a write aborts it.
    txn(1'b1, 16'd3, 16'h0001, 2'b11);
    txn(1'b0, 16'd5, 16'h0000, 2'b00);
    bus.req = 1'b1; bus.we = 1'b1; bus.addr = 16'd3; bus.wdata = 16'h5555; bus.be = 2'b11;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_ack", 32'(bus.ack), 32'd0);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_err", 32'(bus.err), 32'd0);
    chk("abort_rdata", 32'(bus.rdata), 32'd0);
    rd_exp = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    txn(1'b0, 16'd3, 16'h0000, 2'b00);
    chk("abort_no_write", 32'(bus.rdata), 32'h00000001);

    // Address beyond DEPTH: aliases or flags depending on build.
    txn(1'b0, 16'd1029, 16'h0000, 2'b00);
    chk("addr_1029_rdata", 32'(bus.rdata), CHK ? 32'd0 : 32'h0000BEEF);
    chk("addr_1029_model", 32'(bus.rdata), 32'(rd_exp));

    for (int n = 0; n < 60; n++) begin
      logic [AW-1:0] a;
      a = 16'($urandom_range(0, 63));
      if ($urandom_range(0, 3) == 0) a = a + 16'(1024 * $urandom_range(1, 60));
      txn(1'($urandom), a, 16'($urandom), 2'($urandom));
    end

    // Throughput with req held high: one access every WAIT_CYC+2 cycles.
    chk("w0_ack_count_ok", 32'(q0.size() >= 5), 32'd1);
    chk("w15_ack_count_ok", 32'(q15.size() >= 5), 32'd1);
    for (int i = 1; i < q0.size(); i++)  chk("spacing_w0", 32'(q0[i] - q0[i-1]), 32'd2);
    for (int i = 1; i < q15.size(); i++) chk("spacing_w15", 32'(q15[i] - q15[i-1]), 32'd17);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
